// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry sequencer.
//   state_e : entry state machine encoding (3 bits)
//   KEY_*   : keypad codes above the digits 0-9
//   SRC_*   : memory write source select
//   ctrl_t  : registered control pulse bundle driven to the datapath
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        A_ENT  = 3'd1,
        B_ENT  = 3'd2,
        B_IDLE = 3'd3,
        WAIT   = 3'd4,
        RESULT = 3'd5
    } state_e;

    localparam logic [3:0] KEY_CLR = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_RCL = 4'd14;
    localparam logic [3:0] KEY_STO = 4'd15;

    localparam logic [1:0] SRC_A   = 2'd0;
    localparam logic [1:0] SRC_B   = 2'd1;
    localparam logic [1:0] SRC_RES = 2'd2;

    typedef struct packed {
        logic       a_shift;
        logic       b_shift;
        logic       a_clr;
        logic       b_clr;
        logic       op_load;
        logic       op_sub;
        logic       res_to_a;
        logic       mem_store;
        logic [1:0] mem_src;
        logic       mem_load_a;
        logic       mem_load_b;
        logic       alu_start;
        logic       err;
    } ctrl_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_watchdog.sv
// ALU wait watchdog: counts cycles while enabled, flags the last allowed cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count at zero (entry into the wait state)
//   en_i       : count this cycle (sequencer is waiting for the ALU)
//   expire_c   : combinational, high on the cycle whose edge ends the wait budget
module calc_watchdog #(
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c
);

    localparam int unsigned          TMR_W    = $clog2(ALU_TIMEOUT);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(ALU_TIMEOUT - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    // Next count
    always_comb begin
        timer_d = timer_q;
        if (clr_i) begin
            timer_d = '0;
        end else if (en_i) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire_c = en_i && (timer_q == TMR_LAST);

endmodule

// File: rtl/calc_seq.sv
// Calculator entry sequencer: turns accepted keypad codes into one-cycle
// registered control pulses for the operand registers, memory and ALU.
//   clk, rst_n         : clock, asynchronous active-low reset
//   key_valid/key_code : keypad handshake in; key_ready (combinational) out
//   alu_done           : ALU completion, only looked at while waiting
//   a_shift..err       : registered one-cycle control pulses
//   mem_src            : memory write source, qualified by mem_store
//   state, digit_cnt   : current state and digits in the operand being entered
module calc_seq
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    output logic                           key_ready,
    input  logic                           alu_done,
    output logic                           a_shift,
    output logic                           b_shift,
    output logic                           a_clr,
    output logic                           b_clr,
    output logic                           op_load,
    output logic                           op_sub,
    output logic                           res_to_a,
    output logic                           mem_store,
    output logic [1:0]                     mem_src,
    output logic                           mem_load_a,
    output logic                           mem_load_b,
    output logic                           alu_start,
    output logic                           err,
    output logic [2:0]                     state,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt
);

    localparam int unsigned          CNT_W   = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl_q, ctrl_d;

    logic accept, digit, op_key, clr_key, cnt_full;
    logic wd_clr, wd_expire;

    assign key_ready = (state_q != WAIT);
    assign accept    = key_valid && key_ready;
    assign digit     = is_digit(key_code);
    assign op_key    = (key_code == KEY_SUB) || (key_code == KEY_ADD);
    assign clr_key   = (key_code == KEY_CLR);
    assign cnt_full  = (cnt_q >= CNT_MAX);

    calc_watchdog #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wd_clr),
        .en_i     (state_q == WAIT),
        .expire_c (wd_expire)
    );

    // State, digit count and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_A;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state and digit count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_clr  = 1'b0;
        if (accept && clr_key) begin
            state_d = IDLE_A;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE_A: if (accept) begin
                    if (digit) begin
                        state_d = A_ENT;
                        cnt_d   = CNT_ONE;
                    end else if (key_code == KEY_RCL) begin
                        state_d = A_ENT;
                        cnt_d   = CNT_MAX;
                    end
                end
                A_ENT: if (accept) begin
                    if (digit && !cnt_full) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (op_key) begin
                        state_d = B_IDLE;
                        cnt_d   = '0;
                    end
                end
                B_IDLE: if (accept) begin
                    if (digit) begin
                        state_d = B_ENT;
                        cnt_d   = CNT_ONE;
                    end else if (key_code == KEY_RCL) begin
                        state_d = B_ENT;
                        cnt_d   = CNT_MAX;
                    end
                end
                B_ENT: if (accept) begin
                    if (digit && !cnt_full) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (key_code == KEY_EQ) begin
                        state_d = WAIT;
                        wd_clr  = 1'b1;
                    end
                end
                WAIT: begin
                    // done beats a coincident timeout
                    if (alu_done) begin
                        state_d = RESULT;
                    end else if (wd_expire) begin
                        state_d = IDLE_A;
                        cnt_d   = '0;
                    end
                end
                RESULT: if (accept) begin
                    if (digit) begin
                        state_d = A_ENT;
                        cnt_d   = CNT_ONE;
                    end else if (op_key) begin
                        state_d = B_IDLE;
                        cnt_d   = '0;
                    end else if (key_code == KEY_RCL) begin
                        state_d = A_ENT;
                        cnt_d   = CNT_MAX;
                    end
                end
                default: state_d = IDLE_A;
            endcase
        end
    end

    // Control pulses for the cycle after the accepting edge
    always_comb begin
        ctrl_d = '0;
        if (accept && clr_key) begin
            ctrl_d.a_clr = 1'b1;
            ctrl_d.b_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE_A: if (accept) begin
                    if (digit) begin
                        ctrl_d.a_shift = 1'b1;
                    end else if (key_code == KEY_RCL) begin
                        ctrl_d.mem_load_a = 1'b1;
                    end else if (key_code == KEY_STO) begin
                        ctrl_d.mem_store = 1'b1;
                        ctrl_d.mem_src   = SRC_A;
                    end
                end
                A_ENT: if (accept) begin
                    if (digit) begin
                        ctrl_d.a_shift = !cnt_full;
                        ctrl_d.err     = cnt_full;
                    end else if (op_key) begin
                        ctrl_d.op_load = 1'b1;
                        ctrl_d.op_sub  = (key_code == KEY_SUB);
                        ctrl_d.b_clr   = 1'b1;
                    end else if (key_code == KEY_STO) begin
                        ctrl_d.mem_store = 1'b1;
                        ctrl_d.mem_src   = SRC_A;
                    end
                end
                B_IDLE: if (accept) begin
                    if (digit) begin
                        ctrl_d.b_shift = 1'b1;
                    end else if (key_code == KEY_RCL) begin
                        ctrl_d.mem_load_b = 1'b1;
                    end else if (op_key) begin
                        ctrl_d.op_load = 1'b1;
                        ctrl_d.op_sub  = (key_code == KEY_SUB);
                    end
                end
                B_ENT: if (accept) begin
                    if (digit) begin
                        ctrl_d.b_shift = !cnt_full;
                        ctrl_d.err     = cnt_full;
                    end else if (key_code == KEY_EQ) begin
                        ctrl_d.alu_start = 1'b1;
                    end else if (key_code == KEY_STO) begin
                        ctrl_d.mem_store = 1'b1;
                        ctrl_d.mem_src   = SRC_B;
                    end
                end
                WAIT: begin
                    if (!alu_done && wd_expire) begin
                        ctrl_d.err   = 1'b1;
                        ctrl_d.a_clr = 1'b1;
                        ctrl_d.b_clr = 1'b1;
                    end
                end
                RESULT: if (accept) begin
                    if (digit) begin
                        // datapath clears A then appends the digit
                        ctrl_d.a_clr   = 1'b1;
                        ctrl_d.a_shift = 1'b1;
                    end else if (op_key) begin
                        ctrl_d.res_to_a = 1'b1;
                        ctrl_d.op_load  = 1'b1;
                        ctrl_d.op_sub   = (key_code == KEY_SUB);
                        ctrl_d.b_clr    = 1'b1;
                    end else if (key_code == KEY_RCL) begin
                        ctrl_d.mem_load_a = 1'b1;
                    end else if (key_code == KEY_STO) begin
                        ctrl_d.mem_store = 1'b1;
                        ctrl_d.mem_src   = SRC_RES;
                    end
                end
                default: ctrl_d = '0;
            endcase
        end
    end

    assign a_shift    = ctrl_q.a_shift;
    assign b_shift    = ctrl_q.b_shift;
    assign a_clr      = ctrl_q.a_clr;
    assign b_clr      = ctrl_q.b_clr;
    assign op_load    = ctrl_q.op_load;
    assign op_sub     = ctrl_q.op_sub;
    assign res_to_a   = ctrl_q.res_to_a;
    assign mem_store  = ctrl_q.mem_store;
    assign mem_src    = ctrl_q.mem_src;
    assign mem_load_a = ctrl_q.mem_load_a;
    assign mem_load_b = ctrl_q.mem_load_b;
    assign alu_start  = ctrl_q.alu_start;
    assign err        = ctrl_q.err;
    assign state      = state_q;
    assign digit_cnt  = cnt_q;

endmodule
